// File: rtl/pleiads_pkg.sv
// Shared constants for the Pleiads ROM loader: FSM states and the ROM region map
// that the phoenix address decode also uses.
package pleiads_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LOAD  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  // ROM region bases inside the dn_* address space; the palette PROM block is last.
  localparam logic [15:0] PROG_BASE   = 16'h0000;
  localparam logic [15:0] CHR_BG_BASE = 16'h4000;
  localparam logic [15:0] CHR_FG_BASE = 16'h8000;
  localparam logic [15:0] PROM_BASE   = 16'hB000;
  localparam logic [15:0] PROM_SIZE   = 16'h1000;
  localparam logic [15:0] ROM_TOP_DEF = PROM_BASE + PROM_SIZE;

  localparam logic [16:0] BYTE_CNT_MAX = 17'h1FFFF;

  // Full-width compare so high ioctl address bits cannot alias into the ROM map.
  function automatic logic addr_in_rom(input logic [24:0] addr, input logic [15:0] top);
    return addr < {9'd0, top};
  endfunction

endpackage

// File: rtl/pleiads_rom_loader.sv
// ROM download sequencer: registers ioctl writes onto the core dn_* bus, validates the
// image and owns the phoenix core reset (held until a good load, then stretched).
module pleiads_rom_loader
  import pleiads_pkg::*;
#(
  parameter logic [15:0] ROM_TOP   = ROM_TOP_DEF,
  parameter logic [16:0] MIN_BYTES = 17'd49152,
  parameter logic [15:0] RST_HOLD  = 16'd1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        rom_valid,
  output logic        load_err
);

  // Handshake: ioctl_wr is a one-cycle strobe qualified by ioctl_download; every accepted
  // in-range strobe produces exactly one dn_wr pulse one cycle later, with no back-pressure.

  state_e      state_q, state_d;
  logic        dl_q;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        dn_wr_q, dn_wr_d;
  logic        core_reset_q, core_reset_d;
  logic        rom_valid_q, rom_valid_d;
  logic        load_err_q, load_err_d;
  logic [16:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        oor_q, oor_d;

  logic dl_rise;
  logic wr_ok;
  logic in_range;

  always_comb begin
    dl_rise  = ioctl_download & ~dl_q;
    wr_ok    = (state_q == ST_LOAD) & ioctl_download & ioctl_wr;
    in_range = addr_in_rom(ioctl_addr, ROM_TOP);

    dn_wr_d   = wr_ok & in_range;
    dn_addr_d = dn_wr_d ? ioctl_addr[15:0] : dn_addr_q;
    dn_data_d = dn_wr_d ? ioctl_dout : dn_data_q;

    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    oor_d       = oor_q;
    rom_valid_d = rom_valid_q;
    load_err_d  = load_err_q;

    if (dl_rise) begin
      state_d     = ST_LOAD;
      byte_cnt_d  = 17'd0;
      oor_d       = 1'b0;
      rom_valid_d = 1'b0;
      load_err_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (wr_ok) begin
            if (in_range) begin
              if (byte_cnt_q != BYTE_CNT_MAX) byte_cnt_d = byte_cnt_q + 17'd1;
            end else begin
              oor_d = 1'b1;
            end
          end
          // The last strobe always lands while download is high, so its count is already in byte_cnt_q.
          if (!ioctl_download) begin
            if ((byte_cnt_q >= MIN_BYTES) && !oor_q) begin
              state_d     = ST_HOLD;
              hold_cnt_d  = 16'd0;
              rom_valid_d = 1'b1;
            end else begin
              state_d    = ST_FAIL;
              load_err_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (user_reset) begin
            hold_cnt_d = 16'd0;
          end else if (hold_cnt_q == RST_HOLD - 16'd1) begin
            state_d = ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (user_reset) begin
            state_d    = ST_HOLD;
            hold_cnt_d = 16'd0;
          end
        end
        default: ;
      endcase
    end

    core_reset_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      dl_q         <= 1'b0;
      dn_addr_q    <= 16'd0;
      dn_data_q    <= 8'd0;
      dn_wr_q      <= 1'b0;
      core_reset_q <= 1'b1;
      rom_valid_q  <= 1'b0;
      load_err_q   <= 1'b0;
      byte_cnt_q   <= 17'd0;
      hold_cnt_q   <= 16'd0;
      oor_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      core_reset_q <= core_reset_d;
      rom_valid_q  <= rom_valid_d;
      load_err_q   <= load_err_d;
      byte_cnt_q   <= byte_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      oor_q        <= oor_d;
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign core_reset = core_reset_q;
  assign rom_valid  = rom_valid_q;
  assign load_err   = load_err_q;

endmodule
